// File: rtl/ats21.sv
// ats21: alarm/timer scheduler shared by two clients (A and B).
// Holds NUM_BC base clocks and NUM_AT alarm/countdown units; each request carries
// one two-word instruction per client, executed A then B on the word-2 edge.
// Define ATS21_READ_EN to turn opcode 100 into a base-clock read; otherwise it is reserved.
module ats21 #(
    parameter int NUM_BC = 4,
    parameter int NUM_AT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] ctrlA,
    input  logic [15:0] ctrlB,
    output logic        ready,
    output logic [1:0]  stat,
    output logic [23:0] data
);
    localparam int BCW = (NUM_BC > 1) ? $clog2(NUM_BC) : 1;
    localparam int ATW = (NUM_AT > 1) ? $clog2(NUM_AT) : 1;

    // Word-1 fields that carry meaning; word1[5:4] is never used.
    typedef struct packed {
        logic [2:0] op;   // word1[15:13]
        logic [4:0] hi;   // word1[12:8]
        logic [1:0] md;   // word1[7:6]
        logic [3:0] lo;   // word1[3:0]
    } ins_t;

    function automatic logic [2:0] step_of(input logic [1:0] rate);
        case (rate)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic              active, n_active;
    logic [1:0]        at_perm, n_at_perm, bc_perm, n_bc_perm;
    logic [NUM_BC-1:0] bc_en, n_bc_en;
    logic [1:0]        bc_rate [NUM_BC];
    logic [1:0]        n_bc_rate [NUM_BC];
    logic [15:0]       bc_cnt [NUM_BC];
    logic [15:0]       n_bc_cnt [NUM_BC];
    logic [2:0]        step [NUM_BC];
    logic [NUM_AT-1:0] at_en, n_at_en, at_cd, n_at_cd, at_rep, n_at_rep, at_pend, n_at_pend;
    logic [BCW-1:0]    at_bc [NUM_AT];
    logic [BCW-1:0]    n_at_bc [NUM_AT];
    logic [15:0]       at_val [NUM_AT];
    logic [15:0]       n_at_val [NUM_AT];
    logic [15:0]       at_fcnt [NUM_AT];
    logic [15:0]       n_at_fcnt [NUM_AT];

    logic        busy;          // word-2 cycle of an accepted request
    ins_t        ins_a, ins_b;
    logic        b_vld;
    logic [1:0]  b_stat;
    logic [23:0] b_data;
    logic [1:0]  rsp_vld;
    logic [1:0]  rsp_stat [2];
    logic [23:0] rsp_data [2];

    logic           ev_vld, rpt;
    logic [ATW-1:0] ev_idx;

    // Scratch for the per-client decode and per-AT firing logic.
    ins_t           ins;
    logic [15:0]    w2, rdat, ss, rem;
    logic [3:0]     err;
    logic           bcp, atp, bc_ok, at_ok, lo_ok, fire;
    logic [BCW-1:0] bid, lid, sb;
    logic [ATW-1:0] aid;

    // Lowest-numbered pending AT is the next event; it goes out only in a slot with no instruction response.
    always_comb begin
        ev_vld = 1'b0;
        ev_idx = '0;
        for (int j = NUM_AT - 1; j >= 0; j--) begin
            if (at_pend[j]) begin
                ev_vld = 1'b1;
                ev_idx = ATW'(j);
            end
        end
        rpt = ev_vld && !(busy && ins_a.op != 3'b000) && !b_vld;
    end

    // Next state: clock ticks, AT firing, event hand-off, then instruction A followed by instruction B.
    always_comb begin
        n_active  = active;
        n_at_perm = at_perm;
        n_bc_perm = bc_perm;
        n_bc_en   = bc_en;
        n_bc_rate = bc_rate;
        n_at_en   = at_en;
        n_at_cd   = at_cd;
        n_at_rep  = at_rep;
        n_at_pend = at_pend;
        n_at_bc   = at_bc;
        n_at_val  = at_val;
        n_at_fcnt = at_fcnt;
        rsp_vld   = '0;
        rsp_stat[0] = 2'b00;
        rsp_stat[1] = 2'b00;
        rsp_data[0] = '0;
        rsp_data[1] = '0;
        ins = ins_a;
        w2 = ctrlA;
        rdat = ctrlA;
        err = 4'd0;
        bcp = 1'b0;
        atp = 1'b0;
        bc_ok = 1'b0;
        at_ok = 1'b0;
        lo_ok = 1'b0;
        bid = '0;
        lid = '0;
        aid = '0;
        sb = '0;
        ss = '0;
        rem = '0;
        fire = 1'b0;

        for (int i = 0; i < NUM_BC; i++) begin
            step[i] = (active && bc_en[i]) ? step_of(bc_rate[i]) : 3'd0;
            n_bc_cnt[i] = bc_cnt[i] + 16'(step[i]);
        end

        if (rpt) n_at_pend[ev_idx] = 1'b0;

        for (int j = 0; j < NUM_AT; j++) begin
            sb = at_bc[j];
            ss = 16'(step[sb]);
            fire = 1'b0;
            if (at_en[j] && ss != 16'd0) begin
                if (at_cd[j]) begin
                    rem = (at_val[j] <= ss) ? 16'd0 : at_val[j] - ss;
                    n_at_val[j] = rem;
                    fire = (rem == 16'd0);
                end else begin
                    fire = (at_val[j] - bc_cnt[sb] - 16'd1) < ss;
                end
                if (fire) begin
                    n_at_pend[j] = 1'b1;
                    n_at_fcnt[j] = n_bc_cnt[sb];
                    if (at_cd[j] || !at_rep[j]) n_at_en[j] = 1'b0;
                end
            end
        end

        if (busy) begin
            for (int k = 0; k < 2; k++) begin
                ins   = (k == 0) ? ins_a : ins_b;
                w2    = (k == 0) ? ctrlA : ctrlB;
                bcp   = (k == 0) ? n_bc_perm[1] : n_bc_perm[0];
                atp   = (k == 0) ? n_at_perm[1] : n_at_perm[0];
                rdat  = w2;
                err   = 4'd0;
                bc_ok = int'(ins.hi[4:1]) < NUM_BC;
                at_ok = int'(ins.hi) < NUM_AT;
                lo_ok = int'(ins.lo) < NUM_BC;
                bid   = ins.hi[BCW:1];
                aid   = ins.hi[ATW-1:0];
                lid   = ins.lo[BCW-1:0];
                case (ins.op)
                    3'b001: begin
                        if (!bcp) err = 4'd2;
                        else if (!bc_ok) err = 4'd3;
                        else if (ins.md == 2'b11) err = 4'd4;
                        else begin
                            n_bc_rate[bid] = ins.md;
                            n_bc_cnt[bid]  = 16'd0;
                        end
                    end
                    3'b010: begin
                        if (!bcp) err = 4'd2;
                        else if (!bc_ok) err = 4'd3;
                        else n_bc_en[bid] = ins.md[1];
                    end
                    3'b011: begin
                        if (k != 0) err = 4'd2;
                        else {n_active, n_at_perm, n_bc_perm} = ins.hi;
                    end
                    3'b100: begin
`ifdef ATS21_READ_EN
                        if (!bc_ok) err = 4'd3;
                        else rdat = bc_cnt[bid];
`else
                        err = 4'd1;
`endif
                    end
                    3'b101, 3'b110: begin
                        if (!atp) err = 4'd2;
                        else if (!at_ok || !lo_ok) err = 4'd3;
                        else if (ins.op == 3'b110 && w2 == 16'd0) err = 4'd4;
                        else begin
                            n_at_en[aid]  = 1'b1;
                            n_at_cd[aid]  = (ins.op == 3'b110);
                            n_at_rep[aid] = (ins.op == 3'b101) && ins.md[1];
                            n_at_bc[aid]  = lid;
                            n_at_val[aid] = w2;
                        end
                    end
                    3'b111: begin
                        if (!atp) err = 4'd2;
                        else if (!at_ok) err = 4'd3;
                        else begin
                            n_at_en[aid] = ins.md[1];
                            if (!ins.md[1]) n_at_pend[aid] = 1'b0;
                        end
                    end
                    default: ;
                endcase
                rsp_vld[k]  = (ins.op != 3'b000);
                rsp_stat[k] = (err == 4'd0) ? 2'b01 : 2'b10;
                rsp_data[k] = {(k != 0), ins.op, err, rdat};
            end
        end
    end

    // Control state, handshake and the registered stat/data output.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready   <= 1'b0;
            busy    <= 1'b0;
            b_vld   <= 1'b0;
            stat    <= 2'b00;
            data    <= '0;
            active  <= 1'b1;
            at_perm <= 2'b11;
            bc_perm <= 2'b11;
            bc_en   <= '0;
            at_en   <= '0;
            at_cd   <= '0;
            at_rep  <= '0;
            at_pend <= '0;
            for (int i = 0; i < NUM_BC; i++) begin
                bc_rate[i] <= 2'b00;
                bc_cnt[i]  <= 16'd0;
            end
        end else begin
            ready   <= !(ready && req);
            busy    <= ready && req;
            b_vld   <= busy && rsp_vld[1];
            active  <= n_active;
            at_perm <= n_at_perm;
            bc_perm <= n_bc_perm;
            bc_en   <= n_bc_en;
            bc_rate <= n_bc_rate;
            bc_cnt  <= n_bc_cnt;
            at_en   <= n_at_en;
            at_cd   <= n_at_cd;
            at_rep  <= n_at_rep;
            at_pend <= n_at_pend;
            if (busy && rsp_vld[0]) begin
                stat <= rsp_stat[0];
                data <= rsp_data[0];
            end else if (b_vld) begin
                stat <= b_stat;
                data <= b_data;
            end else if (ev_vld) begin
                stat <= 2'b11;
                data <= {5'(ev_idx), 3'b000, at_fcnt[ev_idx]};
            end else begin
                stat <= 2'b00;
                data <= '0;
            end
        end
    end

    // Payload registers: captured words, held B response and per-AT data need no reset.
    always_ff @(posedge clk) begin
        if (ready && req) begin
            ins_a <= ins_t'({ctrlA[15:6], ctrlA[3:0]});
            ins_b <= ins_t'({ctrlB[15:6], ctrlB[3:0]});
        end
        b_stat  <= rsp_stat[1];
        b_data  <= rsp_data[1];
        at_bc   <= n_at_bc;
        at_val  <= n_at_val;
        at_fcnt <= n_at_fcnt;
    end

endmodule

// File: tb/tb_ats21.sv
// Scoreboard bench for ats21: stimulus pushes expected responses, a monitor pops and compares.
module tb_ats21;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [15:0] ctrlA, ctrlB;
    logic        ready;
    logic [1:0]  stat;
    logic [23:0] data;

    typedef struct {
        logic [1:0]  stat;
        logic [23:0] data;
        string       name;
    } exp_t;

    exp_t expq[$];
    int tests = 0;
    int fails = 0;

    ats21 dut (
        .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
        .ready(ready), .stat(stat), .data(data)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [1:0] s, input logic [23:0] d, input string nm);
        exp_t e;
        e.stat = s;
        e.data = d;
        e.name = nm;
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req_v);
        end
    endtask

    // Called at a negedge; returns at the negedge two cycles after acceptance.
    task automatic issue(input logic [15:0] a1, input logic [15:0] a2,
                         input logic [15:0] b1, input logic [15:0] b2);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", {31'd0, ready}, 32'd1);
        req = 1'b1; ctrlA = a1; ctrlB = b1;
        @(negedge clk);
        chk("ready_word2", {31'd0, ready}, 32'd0);
        req = 1'b0; ctrlA = a2; ctrlB = b2;
        @(negedge clk);
        ctrlA = 16'h0; ctrlB = 16'h0;
    endtask

    // Monitor: every non-idle output must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && stat !== 2'b00) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got stat=%b data=%h, expected none", stat, data);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (stat !== e.stat || data !== e.data) begin
                    fails++;
                    $display("FAIL %s: got stat=%b data=%h, expected stat=%b data=%h",
                             e.name, stat, data, e.stat, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = 1'b0; ctrlA = 16'h0; ctrlB = 16'h0;
        repeat (4) begin
            @(negedge clk);
            chk("reset_ready", {31'd0, ready}, 32'd0);
            chk("reset_stat", {30'd0, stat}, 32'd0);
            chk("reset_data", {8'd0, data}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, ready}, 32'd1);

        // Set BC0 1X from A and BC1 2X from B.
        push_exp(2'b01, 24'h100000, "setclk_a");
        push_exp(2'b01, 24'h900000, "setclk_b");
        issue(16'h2000, 16'h0000, 16'h2240, 16'h0000);
        repeat (4) @(negedge clk);

        // Enable BC0, then a one-shot alarm on AT3 at t=10.
        push_exp(2'b01, 24'h200000, "bc0_enable");
        issue(16'h4080, 16'h0000, 16'h0000, 16'h0000);
        push_exp(2'b01, 24'h50000A, "alarm_ack");
        push_exp(2'b11, 24'h18000A, "alarm_event");
        issue(16'hA300, 16'h000A, 16'h0000, 16'h0000);
        repeat (20) @(negedge clk);

        // B may not change the mode.
        push_exp(2'b10, 24'hB20000, "mode_from_b");
        issue(16'h0000, 16'h0000, 16'h7000, 16'h0000);
        repeat (3) @(negedge clk);

        // A revokes all permissions, both clients are refused, then A restores them.
        push_exp(2'b01, 24'h300000, "mode_revoke");
        issue(16'h7000, 16'h0000, 16'h0000, 16'h0000);
        push_exp(2'b10, 24'h120000, "bc_perm_a");
        push_exp(2'b10, 24'hD20001, "at_perm_b");
        issue(16'h2000, 16'h0000, 16'hA300, 16'h0001);
        push_exp(2'b01, 24'h300000, "mode_restore");
        issue(16'h7F00, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);

        // Illegal rate, out-of-range ids and zero interval.
        push_exp(2'b10, 24'h140000, "rate_11");
        issue(16'h20C0, 16'h0000, 16'h0000, 16'h0000);
        push_exp(2'b10, 24'h130000, "bc_id_range");
        push_exp(2'b10, 24'hE40000, "cd_zero");
        issue(16'h2800, 16'h0000, 16'hC101, 16'h0000);
        push_exp(2'b10, 24'h531234, "at_id_range");
        push_exp(2'b10, 24'hD30007, "alarm_bc_range");
        issue(16'hA800, 16'h1234, 16'hA304, 16'h0007);
`ifdef ATS21_READ_EN
        push_exp(2'b01, 24'h400000, "read_bc2");
`else
        push_exp(2'b10, 24'h415555, "reserved_op");
`endif
        issue(16'h8400, 16'h5555, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);

        // Countdown of 5 on BC1 at 2X, with the count cleared on the same edge.
        push_exp(2'b01, 24'h200000, "bc1_enable");
        issue(16'h4280, 16'h0000, 16'h0000, 16'h0000);
        push_exp(2'b01, 24'h100000, "bc1_clear");
        push_exp(2'b01, 24'hE00005, "cd_ack");
        push_exp(2'b11, 24'h080006, "cd_event");
        issue(16'h2240, 16'h0000, 16'hC101, 16'h0005);
        repeat (30) @(negedge clk);

        chk("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
